// File: rtl/fixed_add_seq_if.sv
// Memory and adder bus of the fixed-point vector-add sequencer.
// master: sequencer side (drives address/strobes/write data and adder operands).
// slave : memory + combinational adder side (returns read data and sum/saturation flag).
interface fixed_add_seq_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
);
   // Shared single-port memory: read data arrives one cycle after mem_rd_en.
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_rd_en;
   logic                  mem_wr_en;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // External combinational saturating adder.
   logic [DATA_WIDTH-1:0] add_a;
   logic [DATA_WIDTH-1:0] add_b;
   logic [DATA_WIDTH-1:0] add_out;
   logic                  add_v;

   modport master (
      output mem_addr, mem_rd_en, mem_wr_en, mem_wdata, add_a, add_b,
      input  mem_rdata, add_out, add_v
   );

   modport slave (
      input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata, add_a, add_b,
      output mem_rdata, add_out, add_v
   );
endinterface

// File: rtl/fixed_add_seq.sv
// Fixed-point vector add sequencer: out[i] = sat(A[i] + B[i]) over a shared memory.
// Latency: 5 cycles per element, start-to-done 5*length+1 cycles (1 cycle for length 0).
// Backpressure: none; start is only sampled in IDLE, later starts are dropped.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   start, base_a/b/out, length     job request and parameters (captured on accept)
//   busy, done                      job in progress / one-cycle completion pulse
//   ovf_sticky, ovf_count           saturation summary of the current/last job
//   bus (fixed_add_seq_if.master)   memory port and external adder operands/result
module fixed_add_seq #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_a,
   input  logic [ADDR_WIDTH-1:0] base_b,
   input  logic [ADDR_WIDTH-1:0] base_out,
   input  logic [ADDR_WIDTH-1:0] length,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf_sticky,
   output logic [ADDR_WIDTH-1:0] ovf_count,
   fixed_add_seq_if.master       bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RD_A  = 3'd1,
      S_RD_B  = 3'd2,
      S_LAT_B = 3'd3,
      S_ADD   = 3'd4,
      S_WR    = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t state_q;
   state_t state_d;

   // Captured job parameters and element index.
   logic [ADDR_WIDTH-1:0] base_a_q;
   logic [ADDR_WIDTH-1:0] base_b_q;
   logic [ADDR_WIDTH-1:0] base_out_q;
   logic [ADDR_WIDTH-1:0] len_q;
   logic [ADDR_WIDTH-1:0] idx_q;

   // Operand, result and saturation tracking registers.
   logic [DATA_WIDTH-1:0] add_a_q;
   logic [DATA_WIDTH-1:0] add_b_q;
   logic [DATA_WIDTH-1:0] result_q;
   logic                  ovf_sticky_q;
   logic [ADDR_WIDTH-1:0] ovf_count_q;

   // Decoded controls from the FSM.
   logic                  cap_job;
   logic                  clr_flags;
   logic                  ld_a;
   logic                  ld_b;
   logic                  ld_res;
   logic                  inc_idx;
   logic                  last_elem;

   logic [ADDR_WIDTH-1:0] mem_addr_c;
   logic                  mem_rd_c;
   logic                  mem_wr_c;
   logic [DATA_WIDTH-1:0] mem_wdata_c;
   logic                  busy_c;
   logic                  done_c;

   // Index compare is only reached with len_q != 0, so len_q-1 never underflows.
   assign last_elem = (idx_q == (len_q - ADDR_WIDTH'(1)));

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // Next state and Moore outputs. Memory address is forced to zero in
   // every state that does not access memory.
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      mem_addr_c  = '0;
      mem_rd_c    = 1'b0;
      mem_wr_c    = 1'b0;
      mem_wdata_c = '0;
      busy_c      = 1'b0;
      done_c      = 1'b0;
      cap_job     = 1'b0;
      clr_flags   = 1'b0;
      ld_a        = 1'b0;
      ld_b        = 1'b0;
      ld_res      = 1'b0;
      inc_idx     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               clr_flags = 1'b1;
               if (length != '0) begin
                  cap_job = 1'b1;
                  state_d = S_RD_A;
               end else begin
                  // Empty job: report completion without touching memory.
                  state_d = S_DONE;
               end
            end
         end

         S_RD_A: begin
            busy_c     = 1'b1;
            mem_addr_c = base_a_q + idx_q;
            mem_rd_c   = 1'b1;
            state_d    = S_RD_B;
         end

         S_RD_B: begin
            // A[i] is on mem_rdata this cycle; B[i] read is issued.
            busy_c     = 1'b1;
            mem_addr_c = base_b_q + idx_q;
            mem_rd_c   = 1'b1;
            ld_a       = 1'b1;
            state_d    = S_LAT_B;
         end

         S_LAT_B: begin
            busy_c  = 1'b1;
            ld_b    = 1'b1;
            state_d = S_ADD;
         end

         S_ADD: begin
            // Operands have been registered for a full cycle; sample the adder.
            busy_c  = 1'b1;
            ld_res  = 1'b1;
            state_d = S_WR;
         end

         S_WR: begin
            // Both reads of element i are complete, so aliasing base_out is safe.
            busy_c      = 1'b1;
            mem_addr_c  = base_out_q + idx_q;
            mem_wr_c    = 1'b1;
            mem_wdata_c = result_q;
            if (last_elem) begin
               state_d = S_DONE;
            end else begin
               inc_idx = 1'b1;
               state_d = S_RD_A;
            end
         end

         S_DONE: begin
            done_c  = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Job parameters and element index
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_a_q   <= '0;
         base_b_q   <= '0;
         base_out_q <= '0;
         len_q      <= '0;
         idx_q      <= '0;
      end else begin
         if (cap_job) begin
            base_a_q   <= base_a;
            base_b_q   <= base_b;
            base_out_q <= base_out;
            len_q      <= length;
            idx_q      <= '0;
         end else if (inc_idx) begin
            idx_q <= idx_q + ADDR_WIDTH'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Operand / result registers and saturation tracking
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         add_a_q      <= '0;
         add_b_q      <= '0;
         result_q     <= '0;
         ovf_sticky_q <= 1'b0;
         ovf_count_q  <= '0;
      end else begin
         if (ld_a) begin
            add_a_q <= bus.mem_rdata;
         end
         if (ld_b) begin
            add_b_q <= bus.mem_rdata;
         end
         if (clr_flags) begin
            ovf_sticky_q <= 1'b0;
            ovf_count_q  <= '0;
         end else if (ld_res) begin
            result_q <= bus.add_out;
            if (bus.add_v) begin
               ovf_sticky_q <= 1'b1;
               // Count holds at all-ones rather than wrapping back to zero.
               if (ovf_count_q != '1) begin
                  ovf_count_q <= ovf_count_q + ADDR_WIDTH'(1);
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.mem_addr  = mem_addr_c;
   assign bus.mem_rd_en = mem_rd_c;
   assign bus.mem_wr_en = mem_wr_c;
   assign bus.mem_wdata = mem_wdata_c;
   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;

   assign busy       = busy_c;
   assign done       = done_c;
   assign ovf_sticky = ovf_sticky_q;
   assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_fixed_add_seq.sv
// Bench for fixed_add_seq: behavioural memory + saturating Q7.8 adder, directed
// vector table, hand-written multi-cycle sequences and randomized jobs checked
// against a sequential array model of the vector add.
module tb_fixed_add_seq;
   localparam int DW = 16;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start;
   logic [AW-1:0] base_a, base_b, base_out, length;
   logic          busy, done, ovf_sticky;
   logic [AW-1:0] ovf_count;

   always #5 clk = ~clk;

   fixed_add_seq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   fixed_add_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_a    (base_a),
      .base_b    (base_b),
      .base_out  (base_out),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .ovf_sticky(ovf_sticky),
      .ovf_count (ovf_count),
      .bus       (bus)
   );

   // Signed Q7.8 add with saturation; bit 16 flags saturation.
   function automatic logic [16:0] sat_add(input logic [15:0] a, input logic [15:0] b);
      int s;
      s = int'($signed(a)) + int'($signed(b));
      if (s > 32767)       return {1'b1, 16'h7FFF};
      else if (s < -32768) return {1'b1, 16'h8000};
      else                 return {1'b0, s[15:0]};
   endfunction

   // External combinational adder.
   always_comb begin
      {bus.add_v, bus.add_out} = sat_add(bus.add_a, bus.add_b);
   end

   // Memory model and bus monitors.
   logic [15:0] mem [256];
   logic [15:0] mdl [256];
   logic [7:0]  rd_log [$];
   int n_rd = 0, n_wr = 0, n_done = 0, n_both = 0, n_addr_bad = 0;

   always @(posedge clk) begin
      if (bus.mem_rd_en) begin
         bus.mem_rdata <= mem[bus.mem_addr];
         n_rd <= n_rd + 1;
         rd_log.push_back(bus.mem_addr);
      end
      if (bus.mem_wr_en) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
         n_wr <= n_wr + 1;
      end
      if (bus.mem_rd_en && bus.mem_wr_en) n_both <= n_both + 1;
      if (!bus.mem_rd_en && !bus.mem_wr_en && bus.mem_addr != '0) n_addr_bad <= n_addr_bad + 1;
      if (done) n_done <= n_done + 1;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue a job, return start-to-done latency (-1 on timeout) and busy one
   // cycle after accept. glitch_at>0 raises a bogus start in that cycle.
   task automatic run_job(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] bo,
                          input logic [7:0] len, input bit rel_rst, input int glitch_at,
                          output int lat, output logic busy1);
      int n;
      @(negedge clk);
      if (rel_rst) rst_n = 1'b1;
      base_a = ba; base_b = bb; base_out = bo; length = len; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      busy1 = busy;
      n = 1;
      while (!done && n < 400) begin
         @(posedge clk); #1;
         n++;
         if (n == glitch_at) begin
            start = 1'b1; base_a = ~ba; base_b = ~bb; base_out = ~bo; length = 8'd1;
         end else begin
            start = 1'b0;
         end
      end
      lat = done ? n : -1;
      start = 1'b0;
   endtask

   typedef struct packed {
      logic [7:0]       ba, bb, bo, len, oc;
      logic [2:0][15:0] a, b, w;
   } vec_t;

   function automatic vec_t mkvec(input logic [7:0] ba, bb, bo, len,
                                  input logic [15:0] a0, a1, a2, b0, b1, b2, w0, w1, w2,
                                  input logic [7:0] oc);
      vec_t t;
      t.ba = ba; t.bb = bb; t.bo = bo; t.len = len; t.oc = oc;
      t.a[0] = a0; t.a[1] = a1; t.a[2] = a2;
      t.b[0] = b0; t.b[1] = b1; t.b[2] = b2;
      t.w[0] = w0; t.w[1] = w1; t.w[2] = w2;
      return t;
   endfunction

   initial begin
      vec_t vecs[5];
      int   lat, rd0, wr0, d0;
      logic b1;

      start = 0; base_a = 0; base_b = 0; base_out = 0; length = 0;
      for (int k = 0; k < 256; k++) mem[k] = 16'h0;

      vecs[0] = mkvec(8'h00, 8'h10, 8'h20, 8'd2, 16'h0180, 16'h0040, 16'h0, 16'h0100, 16'h0040, 16'h0,
                      16'h0280, 16'h0080, 16'h0, 8'd0);
      vecs[1] = mkvec(8'h30, 8'h40, 8'h50, 8'd3, 16'h7000, 16'h0100, 16'h8000, 16'h2000, 16'h0100, 16'h9000,
                      16'h7FFF, 16'h0200, 16'h8000, 8'd2);
      vecs[2] = mkvec(8'h60, 8'h61, 8'h62, 8'd0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                      16'h0, 16'h0, 16'h0, 8'd0);
      vecs[3] = mkvec(8'hFE, 8'h40, 8'h80, 8'd3, 16'h0001, 16'h0002, 16'h0003, 16'h0010, 16'h0020, 16'h0030,
                      16'h0011, 16'h0022, 16'h0033, 8'd0);
      vecs[4] = mkvec(8'hA0, 8'hB0, 8'hC0, 8'd2, 16'hFF00, 16'h8001, 16'h0, 16'h0080, 16'hFFFF, 16'h0,
                      16'hFF80, 16'h8000, 16'h0, 8'd0);

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", bus.mem_rd_en, 0);
      chk("rst_wr_en", bus.mem_wr_en, 0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_wdata", bus.mem_wdata, 0);
      chk("rst_add_a", bus.add_a, 0);
      chk("rst_add_b", bus.add_b, 0);
      chk("rst_sticky", ovf_sticky, 0);
      chk("rst_count", ovf_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table.
      for (int v = 0; v < 5; v++) begin
         vec_t t;
         t = vecs[v];
         for (int i = 0; i < int'(t.len); i++) begin
            mem[8'(t.ba + i)] = t.a[i];
            mem[8'(t.bb + i)] = t.b[i];
            mem[8'(t.bo + i)] = 16'hDEAD;
         end
         rd0 = n_rd; wr0 = n_wr; d0 = n_done;
         rd_log.delete();
         run_job(t.ba, t.bb, t.bo, t.len, 1'b0, 0, lat, b1);
         chk($sformatf("vec%0d_latency", v), lat, 5 * int'(t.len) + 1);
         chk($sformatf("vec%0d_busy_after_start", v), b1, (t.len != 0));
         chk($sformatf("vec%0d_busy_at_done", v), busy, 0);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_done_pulses", v), n_done - d0, 1);
         chk($sformatf("vec%0d_done_width", v), done, 0);
         chk($sformatf("vec%0d_reads", v), n_rd - rd0, 2 * int'(t.len));
         chk($sformatf("vec%0d_writes", v), n_wr - wr0, int'(t.len));
         for (int i = 0; i < int'(t.len); i++)
            chk($sformatf("vec%0d_out%0d", v, i), mem[8'(t.bo + i)], t.w[i]);
         chk($sformatf("vec%0d_ovf_count", v), ovf_count, t.oc);
         chk($sformatf("vec%0d_ovf_sticky", v), ovf_sticky, (t.oc != 0));
         if (t.ba == 8'hFE) begin
            chk("wrap_rd_a0", rd_log[0], 8'hFE);
            chk("wrap_rd_a1", rd_log[2], 8'hFF);
            chk("wrap_rd_a2", rd_log[4], 8'h00);
         end
         repeat (2) @(posedge clk);
         #1;
         chk($sformatf("vec%0d_ovf_hold", v), ovf_count, t.oc);
         chk($sformatf("vec%0d_idle", v), busy, 0);
      end

      // Randomized jobs (job 1 also sees a start while busy).
      for (int j = 0; j < 8; j++) begin
         logic [7:0]  ba, bb, bo, len;
         logic [16:0] r;
         int          exp_ovf, bad;
         ba = 8'($urandom); bb = 8'($urandom); bo = 8'($urandom);
         len = 8'($urandom_range(1, 12));
         for (int k = 0; k < 256; k++) mem[k] = 16'($urandom);
         for (int k = 0; k < 256; k++) mdl[k] = mem[k];
         exp_ovf = 0;
         for (int i = 0; i < int'(len); i++) begin
            r = sat_add(mdl[8'(ba + i)], mdl[8'(bb + i)]);
            mdl[8'(bo + i)] = r[15:0];
            exp_ovf += int'(r[16]);
         end
         run_job(ba, bb, bo, len, 1'b0, (j == 1) ? 3 : 0, lat, b1);
         chk($sformatf("rnd%0d_latency", j), lat, 5 * int'(len) + 1);
         @(posedge clk); #1;
         bad = 0;
         for (int k = 0; k < 256; k++) if (mem[k] !== mdl[k]) bad++;
         chk($sformatf("rnd%0d_mem_image_errors", j), bad, 0);
         chk($sformatf("rnd%0d_ovf_count", j), ovf_count, exp_ovf);
         chk($sformatf("rnd%0d_ovf_sticky", j), ovf_sticky, (exp_ovf != 0));
         repeat (2) @(posedge clk);
         #1;
         chk($sformatf("rnd%0d_idle", j), busy, 0);
      end

      // Reset during WR of element 1.
      for (int i = 0; i < 3; i++) begin
         mem[i] = 16'(i + 1);
         mem[8'h10 + i] = 16'(16 * (i + 1));
         mem[8'h20 + i] = 16'hDEAD;
      end
      d0 = n_done; wr0 = n_wr;
      @(negedge clk);
      base_a = 8'h00; base_b = 8'h10; base_out = 8'h20; length = 8'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 1; n < 10; n++) begin
         @(posedge clk); #1;
      end
      chk("abort_in_wr1", bus.mem_wr_en, 1);
      chk("abort_wr1_addr", bus.mem_addr, 8'h21);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_wr_en", bus.mem_wr_en, 0);
      chk("abort_rd_en", bus.mem_rd_en, 0);
      chk("abort_addr", bus.mem_addr, 0);
      chk("abort_wdata", bus.mem_wdata, 0);
      chk("abort_add_a", bus.add_a, 0);
      chk("abort_add_b", bus.add_b, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_elem0_written", mem[8'h20], 16'h0011);
      chk("abort_elem1_untouched", mem[8'h21], 16'hDEAD);
      chk("abort_write_count", n_wr - wr0, 1);
      chk("abort_no_done", n_done - d0, 0);

      // Fresh job accepted on the first edge after reset release.
      mem[8'h00] = 16'h0180; mem[8'h01] = 16'h0040;
      mem[8'h10] = 16'h0100; mem[8'h11] = 16'h0040;
      run_job(8'h00, 8'h10, 8'h20, 8'd2, 1'b1, 0, lat, b1);
      chk("post_rst_latency", lat, 11);
      @(posedge clk); #1;
      chk("post_rst_out0", mem[8'h20], 16'h0280);
      chk("post_rst_out1", mem[8'h21], 16'h0080);
      chk("post_rst_sticky", ovf_sticky, 0);

      // Whole-run bus invariants.
      chk("rd_wr_both_high", n_both, 0);
      chk("addr_nonzero_idle", n_addr_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
